// File: rtl/rr_grant4_if.sv
// Arbiter request/grant bundle: requesters drive req/done, arbiter returns grant status.
interface rr_grant4_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic       grant_valid;
  logic       timeout;
  logic [1:0] ptr;

  modport master (
    output req,
    output done,
    input  grant,
    input  grant_valid,
    input  timeout,
    input  ptr
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_valid,
    output timeout,
    output ptr
  );
endinterface

// File: rtl/rr_grant4.sv
// 4-requester round-robin arbiter with registered one-hot grant, done/withdraw
// release, and a hold-timeout watchdog. Every release is followed by one idle
// cycle so the downstream grant encoder never sees back-to-back owners.
module rr_grant4 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  rr_grant4_if.slave  bus
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]       cand;
  logic [1:0]       sel_idx;
  logic             sel_found;
  logic             owner_req;
  logic             hold_max;

  // Round-robin pick: first requester at or after ptr, wrapping mod 4.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = ptr_q;
    cand      = ptr_q;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!sel_found && bus.req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign owner_req = bus.req[owner_q];
  assign hold_max  = (cnt_q == CNT_W'(MAX_HOLD));

  // Next-state and next-output logic; release priority is done, withdraw, timeout.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;

    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        valid_d = 1'b0;
        cnt_d   = '0;
        if (sel_found) begin
          state_d = ST_GRANT;
          grant_d = 4'(4'b0001 << sel_idx);
          valid_d = 1'b1;
          owner_d = sel_idx;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_GRANT: begin
        if (bus.done || !owner_req || hold_max) begin
          state_d   = ST_IDLE;
          grant_d   = '0;
          valid_d   = 1'b0;
          cnt_d     = '0;
          ptr_d     = owner_q + 2'd1;
          timeout_d = !bus.done && owner_req;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = valid_q;
  assign bus.timeout     = timeout_q;
  assign bus.ptr         = ptr_q;

endmodule

// File: tb/tb_rr_grant4.sv
// Directed bench for rr_grant4: each step drives inputs, queues the expected
// post-edge outputs, then pops and checks them after the edge.
module tb_rr_grant4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  typedef struct packed {
    logic [3:0] g;
    logic       t;
    logic [1:0] p;
  } exp_t;

  exp_t exp_q[$];

  rr_grant4_if bus ();

  rr_grant4 #(.MAX_HOLD(16), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock step: drive, queue expectation, wait edge, pop and compare.
  task automatic cyc(input logic [3:0] r, input logic d, input logic rn,
                     input logic [3:0] eg, input logic et, input logic [1:0] ep,
                     input string tag);
    exp_t e;
    bus.req  = r;
    bus.done = d;
    rst_n    = rn;
    exp_q.push_back({eg, et, ep});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    total++;
    assert (bus.grant === e.g) else begin
      bad++;
      $error("FAIL %s grant got=%b exp=%b", tag, bus.grant, e.g);
    end
    total++;
    assert (bus.timeout === e.t) else begin
      bad++;
      $error("FAIL %s timeout got=%b exp=%b", tag, bus.timeout, e.t);
    end
    total++;
    assert (bus.ptr === e.p) else begin
      bad++;
      $error("FAIL %s ptr got=%0d exp=%0d", tag, bus.ptr, e.p);
    end
    total++;
    assert (bus.grant_valid === (|e.g)) else begin
      bad++;
      $error("FAIL %s grant_valid got=%b exp=%b", tag, bus.grant_valid, |e.g);
    end
    total++;
    assert ($onehot0(bus.grant) === 1'b1) else begin
      bad++;
      $error("FAIL %s onehot0 grant=%b", tag, bus.grant);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "test done: total=%0d bad=%0d", total, bad + 1);
  end

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.done = 1'b0;

    // Reset state
    cyc(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, "reset0");
    cyc(4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, "reset1");
    cyc(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, "idle");

    // All requesting, done on 3rd grant cycle: rotates 0,1,2,3 with one bubble each
    for (int k = 0; k < 4; k++) begin
      cyc(4'b1111, 1'b0, 1'b1, 4'(4'b0001 << k), 1'b0, 2'(k), "rr_g1");
      cyc(4'b1111, 1'b0, 1'b1, 4'(4'b0001 << k), 1'b0, 2'(k), "rr_g2");
      cyc(4'b1111, 1'b0, 1'b1, 4'(4'b0001 << k), 1'b0, 2'(k), "rr_g3");
      cyc(4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0, 2'(k + 1), "rr_rel");
    end
    cyc(4'b1111, 1'b0, 1'b1, 4'b0001, 1'b0, 2'd0, "rr_wrap");
    cyc(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd1, "rr_drop");

    // Timeout: requester 2 holds forever, gets exactly 16 cycles
    for (int i = 0; i < 16; i++)
      cyc(4'b0100, 1'b0, 1'b1, 4'b0100, 1'b0, 2'd1, "to_hold");
    cyc(4'b0100, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd3, "to_fire");
    cyc(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd3, "to_clear");

    // Fairness from ptr=3 with req 1001, then withdraw on 2nd grant cycle
    cyc(4'b1001, 1'b0, 1'b1, 4'b1000, 1'b0, 2'd3, "fair_g3");
    cyc(4'b1001, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, "fair_rel");
    cyc(4'b1001, 1'b0, 1'b1, 4'b0001, 1'b0, 2'd0, "fair_g0");
    cyc(4'b0001, 1'b0, 1'b1, 4'b0001, 1'b0, 2'd0, "wd_g2");
    cyc(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd1, "wd_rel");

    // done coincides with counter==MAX_HOLD: normal release, no timeout
    for (int i = 0; i < 16; i++)
      cyc(4'b0010, 1'b0, 1'b1, 4'b0010, 1'b0, 2'd1, "dm_hold");
    cyc(4'b0010, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd2, "dm_rel");
    cyc(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd2, "dm_idle");

    // done while idle is ignored
    cyc(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd2, "idle_done");

    // Non-owner requests during grant are ignored and not latched
    cyc(4'b0100, 1'b0, 1'b1, 4'b0100, 1'b0, 2'd2, "nl_g");
    cyc(4'b1100, 1'b0, 1'b1, 4'b0100, 1'b0, 2'd2, "nl_hold");
    cyc(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd3, "nl_rel");
    cyc(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd3, "nl_idle");

    // Mid-grant reset, then req 0110 grants requester 1 from ptr=0
    for (int i = 0; i < 5; i++)
      cyc(4'b0010, 1'b0, 1'b1, 4'b0010, 1'b0, 2'd3, "mr_hold");
    cyc(4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, "mr_reset");
    cyc(4'b0110, 1'b0, 1'b1, 4'b0010, 1'b0, 2'd0, "mr_first");
    cyc(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd2, "mr_rel");

    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_empty got=%0d exp=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
